// File: rtl/iq_power_pkg.sv
// Shared state type, default width and magnitude helper for the I/Q power stage.
package iq_power_pkg;

   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ_I = 2'd1,
      SQ_Q = 2'd2,
      DONE = 2'd3
   } iq_power_state_t;

   // Takes a sign-extended sample; callers truncate to W bits, where |-2^(W-1)| still fits.
   function automatic logic [31:0] abs_w(input logic signed [31:0] x);
      return x[31] ? 32'(-x) : 32'(x);
   endfunction

endpackage

// File: rtl/shift_add_mul.sv
// W x W unsigned shift-add multiplier: loads on i_start, then adds one partial product
// per cycle onto i_acc for W cycles; o_done flags the final step.
module shift_add_mul
   import iq_power_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_start,
   input  logic [W-1:0]   i_multiplicand,
   input  logic [W-1:0]   i_multiplier,
   input  logic [2*W-1:0] i_acc,
   output logic [2*W-1:0] o_product,
   output logic           o_done
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   logic [2*W-1:0] r_mcand;
   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] w_acc_next;
   logic [W-1:0]   r_mplier;
   logic [CW-1:0]  r_count;
   logic           r_busy;
   logic           w_last;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_last     = r_busy && (r_count == CW'(W - 1));
   // Post-step value, so the caller can take the product on the final step edge.
   assign o_product  = w_acc_next;
   assign o_done     = w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= {{W{1'b0}}, i_multiplicand};
         r_mplier <= i_multiplier;
         r_acc    <= i_acc;
         r_count  <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (w_last) begin
            r_count <= '0;
            r_busy  <= 1'b0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/iq_power_sequential.sv
// Sum-of-squares stage: pwr = I*I + Q*Q with ready/valid on both sides, one pair in flight.
// Define IQ_POWER_DUAL_MUL_EN to square I and Q on two concurrent multipliers (latency W, not 2*W).
module iq_power_sequential
   import iq_power_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [W-1:0] i_data,
   input  logic signed [W-1:0] q_data,
   input  logic                iq_vld,
   output logic                iq_rdy,
   output logic [2*W-1:0]      pwr,
   output logic                pwr_vld,
   input  logic                pwr_rdy
);

   iq_power_state_t r_state, w_state_next;
   logic            r_iq_rdy, w_iq_rdy_next;
   logic            r_pwr_vld, w_pwr_vld_next;
   logic [2*W-1:0]  r_pwr, w_pwr_next;
   logic [2*W-1:0]  w_result;
   logic [W-1:0]    w_abs_i, w_abs_q;
   logic            w_accept, w_start, w_done;

   assign w_abs_i  = W'(abs_w(32'(i_data)));
   assign w_abs_q  = W'(abs_w(32'(q_data)));
   assign w_accept = iq_vld && r_iq_rdy;

`ifdef IQ_POWER_DUAL_MUL_EN
   logic [2*W-1:0] w_prod_i, w_prod_q;
   logic           w_done_i, w_done_q;

   assign w_start = w_accept;

   shift_add_mul #(.W(W)) u_mul_i (
      .clk            (clk),
      .reset          (reset),
      .i_start        (w_start),
      .i_multiplicand (w_abs_i),
      .i_multiplier   (w_abs_i),
      .i_acc          ('0),
      .o_product      (w_prod_i),
      .o_done         (w_done_i)
   );

   shift_add_mul #(.W(W)) u_mul_q (
      .clk            (clk),
      .reset          (reset),
      .i_start        (w_start),
      .i_multiplicand (w_abs_q),
      .i_multiplier   (w_abs_q),
      .i_acc          ('0),
      .o_product      (w_prod_q),
      .o_done         (w_done_q)
   );

   assign w_done   = w_done_i && w_done_q;
   assign w_result = w_prod_i + w_prod_q;
`else
   logic [W-1:0]   r_abs_q, w_mcand;
   logic [2*W-1:0] w_acc_in, w_prod;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_abs_q <= '0;
      else if (w_accept) r_abs_q <= w_abs_q;
   end

   // The Q pass restarts the same multiplier seeded with I^2 on the I pass's last step.
   assign w_start  = w_accept || ((r_state == SQ_I) && w_done);
   assign w_mcand  = (r_state == SQ_I) ? r_abs_q : w_abs_i;
   assign w_acc_in = (r_state == SQ_I) ? w_prod : '0;

   shift_add_mul #(.W(W)) u_mul (
      .clk            (clk),
      .reset          (reset),
      .i_start        (w_start),
      .i_multiplicand (w_mcand),
      .i_multiplier   (w_mcand),
      .i_acc          (w_acc_in),
      .o_product      (w_prod),
      .o_done         (w_done)
   );

   assign w_result = w_prod;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_iq_rdy  <= 1'b0;
         r_pwr_vld <= 1'b0;
         r_pwr     <= '0;
      end else begin
         r_state   <= w_state_next;
         r_iq_rdy  <= w_iq_rdy_next;
         r_pwr_vld <= w_pwr_vld_next;
         r_pwr     <= w_pwr_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_iq_rdy_next  = r_iq_rdy;
      w_pwr_vld_next = r_pwr_vld;
      w_pwr_next     = r_pwr;
      case (r_state)
         IDLE: begin
            w_iq_rdy_next = 1'b1;
            if (w_accept) begin
               w_iq_rdy_next = 1'b0;
               w_state_next  = SQ_I;
            end
         end
`ifdef IQ_POWER_DUAL_MUL_EN
         SQ_I: begin
            if (w_done) begin
               w_pwr_next     = w_result;
               w_pwr_vld_next = 1'b1;
               w_state_next   = DONE;
            end
         end
`else
         SQ_I: begin
            if (w_done) w_state_next = SQ_Q;
         end
         SQ_Q: begin
            if (w_done) begin
               w_pwr_next     = w_result;
               w_pwr_vld_next = 1'b1;
               w_state_next   = DONE;
            end
         end
`endif
         DONE: begin
            if (r_pwr_vld && pwr_rdy) begin
               w_pwr_vld_next = 1'b0;
               w_iq_rdy_next  = 1'b1;
               w_state_next   = IDLE;
            end
         end
         default: begin
            w_state_next   = IDLE;
            w_iq_rdy_next  = 1'b0;
            w_pwr_vld_next = 1'b0;
         end
      endcase
   end

   assign iq_rdy  = r_iq_rdy;
   assign pwr_vld = r_pwr_vld;
   assign pwr     = r_pwr;

endmodule

// File: doc/iq_power_sequential.md
Name: iq_power_sequential

Overview:
Sequential sum-of-squares stage that computes I*I + Q*Q for one signed I/Q sample pair, using a shift-add multiplier.
Sits directly upstream of the sequential square-root block: its pwr output drives the root's num input, so the pair together yields the magnitude sqrt(I^2+Q^2).
Ready/valid handshake on both sides; one sample in flight at a time.

Parameters:
W, 8, width of signed I and Q inputs; output width is 2*W, which equals the downstream root's N (default 16).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
i_data  input  W  signed in-phase sample
q_data  input  W  signed quadrature sample
iq_vld  input  1  upstream presents a valid I/Q pair
iq_rdy  output  1  block can accept a pair
pwr  output  2*W  unsigned I^2+Q^2
pwr_vld  output  1  pwr valid
pwr_rdy  input  1  downstream (root) accepts pwr

Behaviour:
- One clock (clk); reset is asynchronous, active-high (reset); every register is cleared immediately on assertion.
- Reset values: iq_rdy=0, pwr_vld=0, pwr=0, state=IDLE, count=0, accumulator and operand registers=0.
- iq_rdy is registered. It goes to 1 on the first clk edge after reset deasserts while in IDLE.
- Accept occurs on an edge with iq_vld&&iq_rdy. On that edge:
  - |i_data| and |q_data| are captured as W-bit unsigned values (|-2^(W-1)| = 2^(W-1) fits).
  - The accumulator is cleared, iq_rdy<=0, state<=SQ_I.
- States:
  - IDLE: wait for accept.
  - SQ_I: W cycles of shift-add. Each cycle, if multiplier LSB=1, add the shifted multiplicand to the accumulator, then shift. count increments from 0; at count==W-1, reset count to 0 and go to SQ_Q.
  - SQ_Q: same W cycles on |q|, accumulating onto the I^2 result. At count==W-1, go to DONE; pwr and pwr_vld<=1 are set on that same edge.
  - DONE: hold pwr and pwr_vld stable. On pwr_vld&&pwr_rdy: pwr_vld<=0, iq_rdy<=1, state<=IDLE.
  - Any illegal encoding goes to IDLE.
- Latency: pwr_vld rises exactly 2*W edges after the accept edge (16 for W=8). Throughput is one result per 2*W+2 cycles with no backpressure.
- Width: the accumulator is 2*W bits unsigned. The maximum 2*(2^(W-1))^2 = 2^(2W-1) never overflows, so no saturation is needed.
- iq_vld while busy is ignored (iq_rdy=0). Upstream must hold data until accepted.
- pwr_rdy is ignored when pwr_vld=0.
- pwr_rdy held low: pwr and pwr_vld are held indefinitely, and no new sample is accepted.
- Reset mid-operation: the partial result is discarded, pwr_vld=0 immediately, and the block returns to IDLE.
- Zero operands still take the full 2*W cycles (no early exit).

Optional Feature:
IQ_POWER_DUAL_MUL_EN
- Defined: two multiplier instances square |I| and |Q| concurrently. States are IDLE, SQ, DONE; the two products are summed at the end of SQ. Latency is W edges from accept to pwr_vld (8 for W=8).
- Undefined: a single shared multiplier with sequential SQ_I then SQ_Q, latency 2*W.
- Handshake, reset and result values are identical in both builds.

Decomposition:
- Package iq_power_pkg:
  - iq_power_state_t enum (IDLE, SQ_I, SQ_Q, DONE; 2-bit)
  - default width constant W_DEF=8
  - helper function abs_w returning an unsigned W-bit magnitude
- Sub-module shift_add_mul: a W x W unsigned sequential multiplier.
  - Ports: start, multiplicand, multiplier, accumulate-in, product, done.
  - Instantiated once, or twice under IQ_POWER_DUAL_MUL_EN.
- count width is $clog2(W).

Test Plan:
- i=3, q=4, pwr_rdy=1 -> pwr=25 with pwr_vld high exactly 16 edges after accept; iq_rdy back high the cycle after the handshake.
- i=-128, q=-128 -> pwr=32768 (0x8000), no overflow; i=127, q=-128 -> pwr=32513.
- i=0, q=0 -> pwr=0 after the full 16 cycles; i=-1, q=1 -> pwr=2.
- Backpressure: pwr_rdy=0 for 5 cycles after pwr_vld -> pwr and pwr_vld stable, iq_rdy=0 while iq_vld is held high. Then pwr_rdy=1 -> a single handshake, and the next pair is accepted 2 cycles later.
- Reset asserted at cycle 7 of SQ_I -> pwr_vld=0 and iq_rdy=0 immediately. After release, i=5, q=12 -> pwr=169.
- Back-to-back stream of 20 random pairs with random pwr_rdy gaps, compared against a reference model. Repeat with IQ_POWER_DUAL_MUL_EN defined, checking latency 8.
